adam_sd_arbiter: RTL

Shares the single HPS SD block port between NUM_REQ sector-buffer requesters (disk and tape drive loaders, each 512-byte sector based). Arbitrates round-robin and presents one LBA plus rd/wr strobe to the SD port. Routes sd_ack, buffer write strobes and write-back data to and from the granted requester only. Sits between the drive loaders and hps_io; requesters keep their existing sd_* handshake unchanged.

---
 rtl/adam_sd_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/adam_sd_arbiter.sv
// Round-robin arbiter sharing one HPS SD block port between NUM_REQ sector-buffer requesters.
// Optional ISSUE watchdog enabled by defining ARB_TIMEOUT_EN.
module adam_sd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int LBA_W     = 32,
    parameter int TIMEOUT_W = 24,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ*LBA_W-1:0] req_lba,
    input  logic [NUM_REQ-1:0]       req_rd,
    input  logic [NUM_REQ-1:0]       req_wr,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [NUM_REQ-1:0]       req_buff_wr,
    input  logic [NUM_REQ*8-1:0]     req_buff_din,
    output logic [NUM_REQ-1:0]       req_error,
    output logic [LBA_W-1:0]         sd_lba,
    output logic                     sd_rd,
    output logic                     sd_wr,
    input  logic                     sd_ack,
    input  logic                     sd_buff_wr,
    output logic [7:0]               sd_buff_din,
    output logic [IDX_W-1:0]         grant,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, RELEASE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, sel_idx;
    logic               sel_vld;
    logic               tmo_hit;
    logic [NUM_REQ-1:0] pending;
    logic [LBA_W-1:0]   lba_arr [NUM_REQ];
    logic [7:0]         din_arr [NUM_REQ];

    assign pending = req_rd | req_wr;
    assign busy    = (state != IDLE);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign lba_arr[i] = req_lba[i*LBA_W +: LBA_W];
        assign din_arr[i] = req_buff_din[i*8 +: 8];
    end

    // Scan downward so the pending index closest to rr_ptr is the last one written.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pending[(int'(rr_ptr) + k) % NUM_REQ]) begin
                sel_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                sel_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = ISSUE;
            ISSUE:   if (sd_ack) state_nxt = XFER;
                     else if (tmo_hit) state_nxt = RELEASE;
            XFER:    if (!sd_ack) state_nxt = RELEASE;
            RELEASE: if (!pending[grant]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rr_ptr is moved past the winner at grant time, so a timed-out requester is skipped too.
    always_ff @(posedge clk) begin
        if (reset) begin
            sd_rd  <= 1'b0;
            sd_wr  <= 1'b0;
            sd_lba <= '0;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: if (sel_vld) begin
                    grant  <= sel_idx;
                    rr_ptr <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                    sd_lba <= lba_arr[sel_idx];
                    sd_wr  <= req_wr[sel_idx];
                    sd_rd  <= ~req_wr[sel_idx];
                end
                ISSUE: if (sd_ack || tmo_hit) begin
                    sd_rd <= 1'b0;
                    sd_wr <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ack            = '0;
        req_buff_wr        = '0;
        req_ack[grant]     = sd_ack & ((state == ISSUE) || (state == XFER));
        req_buff_wr[grant] = sd_buff_wr & sd_ack;
        sd_buff_din        = din_arr[grant];
    end

`ifdef ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;

    assign tmo_hit = (state == ISSUE) && !sd_ack && (&tmo_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt   <= '0;
            req_error <= '0;
        end else begin
            req_error <= '0;
            if (state == IDLE)       tmo_cnt <= '0;
            else if (state == ISSUE) tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) req_error[grant] <= 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign req_error = '0;
`endif

endmodule
